// File: rtl/wb_queue.sv
// Writeback queue: in-order FIFO from ALU/load producers to the register file write port.
// Optional youngest-match read forwarding is compiled in when WBQ_FWD_EN is defined.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [4:0]    mem_dst,
    input  logic [31:0]   mem_data,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [4:0]    alu_dst,
    input  logic [31:0]   alu_data,
    output logic [31:0]   busW,
    output logic          RegWr,
    output logic          RegDst,
    output logic [4:0]    rd,
    output logic [4:0]    rt,
    input  logic [4:0]    RA,
    input  logic [4:0]    RB,
    output logic          fwdA_hit,
    output logic          fwdB_hit,
    output logic [31:0]   fwdA_data,
    output logic [31:0]   fwdB_data,
    output logic [AW:0]   count
);

    logic [4:0]    r_dst  [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;

    logic          w_pop;
    logic          w_drain;
    logic [AW+1:0] w_free;
    logic          w_mem_push;
    logic          w_alu_push;
    logic [AW-1:0] w_alu_slot;
    logic [1:0]    w_pushes;

    assign w_pop = (r_count != '0);

    // The head is popped on the same edge that any push lands, so it counts as a free slot.
    assign w_free    = (AW+2)'(DEPTH) - (AW+2)'(r_count) + (AW+2)'(w_pop);
    assign mem_ready = (w_free != '0);
    assign alu_ready = (w_free >= ((AW+2)'(1) + (AW+2)'(mem_valid)));

    // dst 0 writes are accepted but never stored.
    assign w_mem_push = mem_valid && mem_ready && (mem_dst != 5'd0);
    assign w_alu_push = alu_valid && alu_ready && (alu_dst != 5'd0);
    assign w_alu_slot = w_mem_push ? (r_tail + AW'(1)) : r_tail;
    assign w_pushes   = {1'b0, w_mem_push} + {1'b0, w_alu_push};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_pop);
            r_tail  <= r_tail + AW'(w_pushes);
            r_count <= r_count + (AW+1)'(w_pushes) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (w_mem_push) begin
            r_dst[r_tail]  <= mem_dst;
            r_data[r_tail] <= mem_data;
        end
        if (w_alu_push) begin
            r_dst[w_alu_slot]  <= alu_dst;
            r_data[w_alu_slot] <= alu_data;
        end
    end

    // Write port is suppressed while reset is held so discarded entries never reach the file.
    assign w_drain = w_pop && !reset;
    assign RegWr   = w_drain;
    assign RegDst  = 1'b1;
    assign busW    = w_drain ? r_data[r_head] : 32'd0;
    assign rd      = w_drain ? r_dst[r_head] : 5'd0;
    assign rt      = rd;
    assign count   = r_count;

`ifdef WBQ_FWD_EN
    logic [AW-1:0] w_scan_idx;

    // Walk oldest to youngest so the last match (the youngest) wins.
    always_comb begin
        fwdA_hit   = 1'b0;
        fwdB_hit   = 1'b0;
        fwdA_data  = 32'd0;
        fwdB_data  = 32'd0;
        w_scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_scan_idx = r_head + AW'(k);
            if (((AW+1)'(k) < r_count) && !reset) begin
                if ((RA != 5'd0) && (r_dst[w_scan_idx] == RA)) begin
                    fwdA_hit  = 1'b1;
                    fwdA_data = r_data[w_scan_idx];
                end
                if ((RB != 5'd0) && (r_dst[w_scan_idx] == RB)) begin
                    fwdB_hit  = 1'b1;
                    fwdB_data = r_data[w_scan_idx];
                end
            end
        end
    end
`else
    logic w_unused_fwd;

    assign w_unused_fwd = ^{RA, RB};
    assign fwdA_hit     = 1'b0;
    assign fwdB_hit     = 1'b0;
    assign fwdA_data    = 32'd0;
    assign fwdB_data    = 32'd0;
`endif

endmodule
